// File: rtl/hamming_correct_stage.sv
// Single-error-correction output stage behind the Hamming(7,4) syndrome decoder.
// It corrects data bits, drives a valid/ready stream and keeps saturating error stats with a burst alarm.
module hamming_correct_stage #(
  parameter int CNT_W     = 8,
  parameter int ALARM_RUN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [2:0]       in_error_position,
  input  logic             in_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_corrected,
  output logic [2:0]       out_error_position,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] data_fix_count,
  output logic [CNT_W-1:0] parity_fix_count,
  output logic             alarm
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(ALARM_RUN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_data_q, out_data_d;
  logic             out_corrected_q, out_corrected_d;
  logic [2:0]       out_pos_q, out_pos_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] dfix_q, dfix_d;
  logic [CNT_W-1:0] pfix_q, pfix_d;
  logic [CNT_W-1:0] run_q, run_d;
  state_e           state_q, state_d;
  logic             alarm_q, alarm_d;

  logic             accept_s;
  logic [3:0]       fix_mask_s;
  logic             data_err_s;
  logic             parity_err_s;
  logic             errored_s;
  logic [CNT_W-1:0] run_inc_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign errored_s = data_err_s || parity_err_s;
  assign run_inc_s = run_q + CNT_ONE;

  // Decode the syndrome into a data-bit flip mask and error class.
  always_comb begin
    fix_mask_s   = 4'b0000;
    data_err_s   = 1'b0;
    parity_err_s = 1'b0;
    if (in_error) begin
      case (in_error_position)
        3'd3:                begin fix_mask_s = 4'b0001; data_err_s = 1'b1; end
        3'd5:                begin fix_mask_s = 4'b0010; data_err_s = 1'b1; end
        3'd6:                begin fix_mask_s = 4'b0100; data_err_s = 1'b1; end
        3'd7:                begin fix_mask_s = 4'b1000; data_err_s = 1'b1; end
        3'd1, 3'd2, 3'd4:    parity_err_s = 1'b1;
        default:             fix_mask_s = 4'b0000;
      endcase
    end else begin
      fix_mask_s = 4'b0000;
    end
  end

  // Output register: load on accept, drop valid on a bare transfer, otherwise hold.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_corrected_d = out_corrected_q;
    out_pos_d       = out_pos_q;
    if (accept_s) begin
      out_valid_d     = 1'b1;
      out_data_d      = in_data ^ fix_mask_s;
      out_corrected_d = data_err_s;
      out_pos_d       = in_error_position;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Statistics and burst-alarm next state; a clear outranks a simultaneous accept.
  always_comb begin
    word_d  = word_q;
    dfix_d  = dfix_q;
    pfix_d  = pfix_q;
    run_d   = run_q;
    state_d = state_q;
    alarm_d = alarm_q;
    if (clr_stats) begin
      word_d  = {CNT_W{1'b0}};
      dfix_d  = {CNT_W{1'b0}};
      pfix_d  = {CNT_W{1'b0}};
      run_d   = {CNT_W{1'b0}};
      state_d = ST_OK;
      alarm_d = 1'b0;
    end else if (accept_s) begin
      word_d = sat_inc(word_q, 1'b1);
      dfix_d = sat_inc(dfix_q, data_err_s);
      pfix_d = sat_inc(pfix_q, parity_err_s);
      case (state_q)
        ST_OK, ST_RUN: begin
          if (errored_s) begin
            run_d = run_inc_s;
            if (run_inc_s == RUN_TGT) begin
              state_d = ST_ALARM;
              alarm_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            run_d   = {CNT_W{1'b0}};
            state_d = ST_OK;
          end
        end
        ST_ALARM: alarm_d = 1'b1;
        default: begin
          run_d   = {CNT_W{1'b0}};
          state_d = ST_OK;
          alarm_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_data_q      <= 4'b0000;
      out_corrected_q <= 1'b0;
      out_pos_q       <= 3'd0;
      word_q          <= {CNT_W{1'b0}};
      dfix_q          <= {CNT_W{1'b0}};
      pfix_q          <= {CNT_W{1'b0}};
      run_q           <= {CNT_W{1'b0}};
      state_q         <= ST_OK;
      alarm_q         <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_corrected_q <= out_corrected_d;
      out_pos_q       <= out_pos_d;
      word_q          <= word_d;
      dfix_q          <= dfix_d;
      pfix_q          <= pfix_d;
      run_q           <= run_d;
      state_q         <= state_d;
      alarm_q         <= alarm_d;
    end
  end

  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign out_corrected      = out_corrected_q;
  assign out_error_position = out_pos_q;
  assign word_count         = word_q;
  assign data_fix_count     = dfix_q;
  assign parity_fix_count   = pfix_q;
  assign alarm              = alarm_q;

endmodule

// File: tb/tb_hamming_correct_stage.sv
// Scoreboard bench for hamming_correct_stage: a default instance plus a CNT_W=2 instance for saturation.
module tb_hamming_correct_stage;
  localparam int CW  = 8;
  localparam int AR  = 4;
  localparam int CW2 = 2;
  localparam int AR2 = 3;

  logic clk = 1'b0;
  logic rst, in_valid, in_error, out_ready, clr_stats;
  logic [3:0] in_data;
  logic [2:0] in_pos;

  logic in_ready, out_valid, out_corrected, alarm;
  logic [3:0] out_data;
  logic [2:0] out_pos;
  logic [CW-1:0] word_count, data_fix_count, parity_fix_count;

  logic in_ready2, out_valid2, out_corrected2, alarm2;
  logic [3:0] out_data2;
  logic [2:0] out_pos2;
  logic [CW2-1:0] word_count2, data_fix_count2, parity_fix_count2;

  hamming_correct_stage #(.CNT_W(CW), .ALARM_RUN(AR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_error_position(in_pos), .in_error(in_error), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corrected(out_corrected), .out_error_position(out_pos),
    .clr_stats(clr_stats), .word_count(word_count), .data_fix_count(data_fix_count),
    .parity_fix_count(parity_fix_count), .alarm(alarm));

  hamming_correct_stage #(.CNT_W(CW2), .ALARM_RUN(AR2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_error_position(in_pos), .in_error(in_error), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_corrected(out_corrected2), .out_error_position(out_pos2),
    .clr_stats(clr_stats), .word_count(word_count2), .data_fix_count(data_fix_count2),
    .parity_fix_count(parity_fix_count2), .alarm(alarm2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_e;
  int wc, dfc, pfc, run;
  bit alarm_m;
  int idx_tbl[8] = '{-1, -1, -1, 0, -1, 1, 2, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfers happen at the next rising edge; compare them at the falling edge before it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("out_data", {28'd0, out_data}, {28'd0, mon_e[3:0]});
        check_eq("out_pos", {29'd0, out_pos}, {29'd0, mon_e[6:4]});
        check_eq("out_corrected", {31'd0, out_corrected}, {31'd0, mon_e[7]});
      end
    end
  end

  task automatic model_clear();
    wc = 0; dfc = 0; pfc = 0; run = 0; alarm_m = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] d, input logic [2:0] p, input logic e, input logic clr);
    logic [3:0] m;
    bit corr, err, par;
    m = 4'd0;
    corr = 1'b0;
    if (e && idx_tbl[p] >= 0) begin
      m = 4'(1 << idx_tbl[p]);
      corr = 1'b1;
    end
    sb_q.push_back({corr, p, d ^ m});
    err = e && (p != 3'd0);
    par = err && ((p & (p - 3'd1)) == 3'd0);
    if (clr) begin
      model_clear();
    end else begin
      if (wc < (1 << CW) - 1) wc++;
      if (corr && dfc < (1 << CW) - 1) dfc++;
      if (par && pfc < (1 << CW) - 1) pfc++;
      if (err) begin
        if (!alarm_m) begin
          run++;
          if (run == AR) alarm_m = 1'b1;
        end
      end else if (!alarm_m) begin
        run = 0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [2:0] p, input logic e, input logic v,
                       input logic ordy, input logic clr, output bit acc);
    in_data = d; in_pos = p; in_error = e; in_valid = v; out_ready = ordy; clr_stats = clr;
    #1;
    acc = in_valid && in_ready;
    if (acc) model_accept(d, p, e, clr);
    else if (clr) model_clear();
    @(posedge clk);
    #1;
    check_eq("word_count", {24'd0, word_count}, wc);
    check_eq("data_fix_count", {24'd0, data_fix_count}, dfc);
    check_eq("parity_fix_count", {24'd0, parity_fix_count}, pfc);
    check_eq("alarm", {31'd0, alarm}, {31'd0, alarm_m});
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] p, input logic e,
                      input logic ordy, input logic clr);
    bit acc;
    int n;
    n = 0;
    do begin
      drive(d, p, e, 1'b1, ordy, clr, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    bit acc;
    drive(4'd0, 3'd0, 1'b0, 1'b0, ordy, clr, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    in_data = 4'd0; in_pos = 3'd0; in_error = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    model_clear();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {28'd0, out_data}, 32'd0);
    check_eq("rst_out_corrected", {31'd0, out_corrected}, 32'd0);
    check_eq("rst_out_pos", {29'd0, out_pos}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_word_count", {24'd0, word_count}, 32'd0);
    check_eq("rst_data_fix", {24'd0, data_fix_count}, 32'd0);
    check_eq("rst_alarm", {31'd0, alarm}, 32'd0);
    check_eq("rst_word_count2", {30'd0, word_count2}, 32'd0);
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 5; i++) send(4'hA, 3'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("clean_wc", {24'd0, word_count}, 32'd5);

    send(4'b0110, 3'd7, 1'b1, 1'b1, 1'b0);
    check_eq("lat_d3", {28'd0, out_data}, 32'b1110);
    check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
    send(4'b0110, 3'd3, 1'b1, 1'b1, 1'b0);
    check_eq("lat_d0", {28'd0, out_data}, 32'b0111);
    send(4'b0110, 3'd5, 1'b1, 1'b1, 1'b0);
    check_eq("lat_d1", {28'd0, out_data}, 32'b0100);
    send(4'b0110, 3'd6, 1'b1, 1'b1, 1'b0);
    check_eq("lat_d2", {28'd0, out_data}, 32'b0010);
    send(4'b0110, 3'd5, 1'b0, 1'b1, 1'b0);
    send(4'h9, 3'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1);

    send(4'h5, 3'd4, 1'b1, 1'b1, 1'b0);
    check_eq("parity_data", {28'd0, out_data}, 32'h5);
    check_eq("parity_cnt", {24'd0, parity_fix_count}, 32'd1);
    idle(1'b1, 1'b0);

    // Backpressure: one word parked, the next waits until the sink frees it.
    send(4'h3, 3'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit acc;
      drive(4'hC, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      check_eq("bp_no_accept", {31'd0, acc}, 32'd0);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_hold_data", {28'd0, out_data}, 32'h3);
      check_eq("bp_hold_pos", {29'd0, out_pos}, 32'd1);
    end
    send(4'hC, 3'd6, 1'b1, 1'b1, 1'b0);
    check_eq("bp_next_data", {28'd0, out_data}, 32'h8);
    idle(1'b1, 1'b0);

    idle(1'b1, 1'b1);
    send(4'h1, 3'd3, 1'b1, 1'b1, 1'b0);
    send(4'h2, 3'd2, 1'b1, 1'b1, 1'b0);
    send(4'h4, 3'd7, 1'b1, 1'b1, 1'b0);
    send(4'h7, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(4'(i), 3'd5, 1'b1, 1'b1, 1'b0);
    check_eq("alarm_before", {31'd0, alarm}, 32'd0);
    send(4'hF, 3'd1, 1'b1, 1'b1, 1'b0);
    check_eq("alarm_rise", {31'd0, alarm}, 32'd1);
    send(4'hE, 3'd0, 1'b0, 1'b1, 1'b0);
    send(4'hD, 3'd0, 1'b0, 1'b1, 1'b0);
    check_eq("alarm_sticky", {31'd0, alarm}, 32'd1);
    idle(1'b1, 1'b1);
    check_eq("alarm_clr", {31'd0, alarm}, 32'd0);
    check_eq("clr_wc", {24'd0, word_count}, 32'd0);

    for (int i = 0; i < 5; i++) send(4'h0, 3'd7, 1'b1, 1'b1, 1'b0);
    check_eq("sat_dfix2", {30'd0, data_fix_count2}, 32'd3);
    check_eq("sat_wc2", {30'd0, word_count2}, 32'd3);
    check_eq("sat_alarm2", {31'd0, alarm2}, 32'd1);
    send(4'h1, 3'd0, 1'b0, 1'b1, 1'b0);
    check_eq("sat_hold_wc2", {30'd0, word_count2}, 32'd3);
    send(4'hB, 3'd6, 1'b1, 1'b1, 1'b1);
    check_eq("clr_acc_wc2", {30'd0, word_count2}, 32'd0);
    check_eq("clr_acc_dfix2", {30'd0, data_fix_count2}, 32'd0);
    check_eq("clr_acc_out", {28'd0, out_data}, 32'hF);
    check_eq("clr_acc_valid", {31'd0, out_valid}, 32'd1);
    idle(1'b1, 1'b0);

    send(4'h3, 3'd3, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    check_eq("post_rst_parity", {24'd0, parity_fix_count}, 32'd0);

    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hamming_correct_stage.md
Name: hamming_correct_stage

Overview:
- Registered single-error-correction stage directly downstream of the Hamming(7,4) syndrome decoder.
- Consumes the decoder's extracted 4-bit data, 3-bit error position (syndrome) and error flag.
- Flips the faulty data bit when the syndrome points at a data position and presents corrected nibbles over a valid/ready stream.
- Keeps saturating error statistics and drives a sticky burst-error alarm for system monitoring.

Parameters:
- CNT_W, 8, width of each statistics counter (saturating).
- ALARM_RUN, 4, consecutive errored accepted words that trigger alarm (range 1..2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word
- in_data  input  4  extracted data {d3,d2,d1,d0} from decoder
- in_error_position  input  3  syndrome {c3,c2,c1}, 1..7 = codeword position, 0 = none
- in_error  input  1  decoder error flag
- out_valid  output  1  corrected word valid
- out_ready  input  1  downstream accepts word
- out_data  output  4  corrected data
- out_corrected  output  1  a data bit was flipped in this word
- out_error_position  output  3  registered copy of syndrome for this word
- clr_stats  input  1  clear counters and alarm
- word_count  output  CNT_W  accepted words
- data_fix_count  output  CNT_W  accepted words with a data-bit correction
- parity_fix_count  output  CNT_W  accepted words with error at parity position (1,2,4)
- alarm  output  1  sticky burst-error alarm

Behaviour:
- Reset: out_valid=0, out_data=0, out_corrected=0, out_error_position=0, all counters 0, alarm=0, FSM=OK. in_ready=1 in the cycle after reset.
- Handshake: in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Output register loads on accept. Latency is 1 cycle: accepted at edge N, visible from N. Full throughput (1 word/cycle) when out_ready=1.
- out_valid clears on transfer without a new accept. Output fields hold stable while out_valid && !out_ready.
- Correction applies only if in_error=1:
  - pos 3 flips d0; pos 5 flips d1; pos 6 flips d2; pos 7 flips d3; out_corrected=1.
  - pos 1, 2, 4: data passes unchanged, out_corrected=0, counts as a parity fix.
  - pos 0: no change and not counted as an error.
- If in_error=0, data passes unchanged and the word is not an error word, regardless of pos.
- Counters update on accept only:
  - word_count +1 always.
  - data_fix_count +1 on a data-position error.
  - parity_fix_count +1 on a parity-position error.
  - Each counter saturates at 2^CNT_W-1, no wrap.
- clr_stats:
  - Zeroes all counters, the run counter and alarm next edge; FSM returns to OK.
  - Same cycle as an accept: clear wins, that word is not counted and does not advance the run. The word itself is still corrected and output.
  - clr_stats never affects the datapath or the handshake.
- Alarm FSM, with run counter width CNT_W:
  - OK: errored accept -> run=1, go to RUN (go directly to ALARM if ALARM_RUN=1).
  - RUN: errored accept -> run+1; when run+1 == ALARM_RUN go to ALARM, alarm=1. Clean accept (error-free word) -> run=0, go to OK. No accept -> hold.
  - ALARM: alarm stays 1, counters keep running; exits only on clr_stats or rst.
  - Errored accept means in_error=1 with pos != 0.
- rst mid-stream: a pending output word is discarded (out_valid=0). Stats and alarm are cleared.

Test Plan:
- Clean stream: 5 words in_data=4'hA, in_error=0, out_ready=1 -> out_data=4'hA on each following cycle, out_corrected=0, word_count=5, fix counts 0, alarm=0.
- Data-bit fix: in_data=4'b0110, pos=3'd7, in_error=1 -> out_data=4'b1110, out_corrected=1, data_fix_count=1. Repeat with pos 3, 5, 6 -> d0, d1, d2 flipped respectively.
- Parity fix: in_data=4'h5, pos=3'd4, in_error=1 -> out_data=4'h5, out_corrected=0, parity_fix_count=1.
- Backpressure: hold out_ready=0 with in_valid=1 -> after the first accept in_ready=0, outputs stable, only 1 word counted. Release out_ready -> one transfer, next word accepted in the same cycle, no loss or duplication.
- Alarm: ALARM_RUN=4; pattern of 3 errored, 1 clean, 4 errored accepts -> alarm rises on the edge of the 4th consecutive errored accept and stays 1 through later clean words. clr_stats pulse -> alarm=0, all counters 0.
- Saturation and clear collision: CNT_W=2, 5 errored data-position accepts -> data_fix_count=3 and word_count=3, held. clr_stats asserted together with an accept -> counts 0 next cycle and that word is output but not counted.
